// File: rtl/seq_detector.sv
// seq_detector: serial bit-pattern detector (Moore FSM) with a runtime-programmable
// pattern, an overlapping or non-overlapping match mode, and a saturating match counter.
// Optional macro SEQDET_MASK_EN adds a per-bit don't-care mask (cfg_mask).
//
// state | meaning
// ------+------------------------------------------------------------
// FILL  | fewer than PAT_W valid bits collected since reset/load/hit
// HUNT  | history full, comparing each new valid bit
// HIT   | last evaluated bit completed a match; y is high
module seq_detector #(
   parameter int               PAT_W     = 4,
   parameter int               CNT_W     = 8,
   parameter logic [PAT_W-1:0] PAT_RESET = PAT_W'(4'b1011)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             x,
   input  logic             x_valid,
   input  logic             cfg_load,
   input  logic [PAT_W-1:0] cfg_pattern,
`ifdef SEQDET_MASK_EN
   input  logic [PAT_W-1:0] cfg_mask,
`endif
   input  logic             overlap,
   input  logic             cnt_clr,
   output logic             y,
   output logic [CNT_W-1:0] match_count,
   output logic [1:0]       state_o
);

   localparam int FW = $clog2(PAT_W + 1);
   localparam logic [FW-1:0] FULL = FW'(PAT_W);

   typedef enum logic [1:0] {
      ST_FILL = 2'd0,
      ST_HUNT = 2'd1,
      ST_HIT  = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [PAT_W-1:0] hist;
   logic [PAT_W-1:0] hist_nxt;
   logic [PAT_W-1:0] pattern;
   logic [PAT_W-1:0] mask;
   logic [FW-1:0]    fill;
   logic [FW-1:0]    fill_inc;
   logic [FW-1:0]    fill_nxt;
   logic             hit;

   // Post-shift history, saturating fill and the match condition for this cycle.
   always_comb begin
      hist_nxt = hist;
      fill_inc = fill;
      if (x_valid) begin
         hist_nxt = {hist[PAT_W-2:0], x};
         if (fill != FULL) fill_inc = fill + 1'b1;
      end
      hit = x_valid && (((hist_nxt ^ pattern) & mask) == '0) && (fill_inc == FULL);
   end

   // Next state; a config load always restarts collection in FILL.
   always_comb begin
      state_nxt = ST_FILL;
      case (state)
         ST_FILL: begin
            if (hit)                   state_nxt = ST_HIT;
            else if (fill_inc == FULL) state_nxt = ST_HUNT;
            else                       state_nxt = ST_FILL;
         end
         ST_HUNT: state_nxt = hit ? ST_HIT : ST_HUNT;
         ST_HIT: begin
            // Back-to-back hits only make sense when bits may be shared.
            if (hit && overlap) state_nxt = ST_HIT;
            else if (overlap)   state_nxt = ST_HUNT;
            else                state_nxt = ST_FILL;
         end
         default: state_nxt = ST_FILL;
      endcase
      if (cfg_load) state_nxt = ST_FILL;
   end

   // Non-overlap mode forgets the matched bits so the next match needs PAT_W fresh ones.
   always_comb begin
      fill_nxt = fill_inc;
      if ((state_nxt == ST_HIT) && !overlap) fill_nxt = '0;
   end

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= ST_FILL;
      else          state <= state_nxt;
   end

   // History, fill level and pattern; a load discards any bit sampled with it.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hist    <= '0;
         fill    <= '0;
         pattern <= PAT_RESET;
      end else if (cfg_load) begin
         hist    <= '0;
         fill    <= '0;
         pattern <= cfg_pattern;
      end else begin
         hist <= hist_nxt;
         fill <= fill_nxt;
      end
   end

`ifdef SEQDET_MASK_EN
   // Don't-care mask, all bits significant after reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)      mask <= '1;
      else if (cfg_load) mask <= cfg_mask;
   end
`else
   assign mask = '1;
`endif

   // Saturating match counter; clear wins over a simultaneous hit.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                                      match_count <= '0;
      else if (cnt_clr)                                  match_count <= '0;
      else if ((state_nxt == ST_HIT) && (match_count != '1)) match_count <= match_count + 1'b1;
   end

   assign y       = (state == ST_HIT);
   assign state_o = state;

endmodule

// File: tb/tb_seq_detector.sv
// Directed-vector bench for seq_detector: each applied vector pushes its expected
// outputs into a scoreboard queue; a monitor pops and compares after every clock edge.
module tb_seq_detector;

   localparam int PAT_W = 4;
   localparam int CNT_W = 2;

   logic             clk;
   logic             reset_n;
   logic             x;
   logic             x_valid;
   logic             cfg_load;
   logic [PAT_W-1:0] cfg_pattern;
`ifdef SEQDET_MASK_EN
   logic [PAT_W-1:0] cfg_mask;
`endif
   logic             overlap;
   logic             cnt_clr;
   logic             y;
   logic [CNT_W-1:0] match_count;
   logic [1:0]       state_o;

   seq_detector #(.PAT_W(PAT_W), .CNT_W(CNT_W), .PAT_RESET(4'b1011)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .x           (x),
      .x_valid     (x_valid),
      .cfg_load    (cfg_load),
      .cfg_pattern (cfg_pattern),
`ifdef SEQDET_MASK_EN
      .cfg_mask    (cfg_mask),
`endif
      .overlap     (overlap),
      .cnt_clr     (cnt_clr),
      .y           (y),
      .match_count (match_count),
      .state_o     (state_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic             y;
      logic [CNT_W-1:0] cnt;
      logic [1:0]       st;
   } exp_t;

   typedef struct {
      logic             rst;
      logic             v;
      logic             b;
      logic             ld;
      logic [PAT_W-1:0] pat;
      logic [PAT_W-1:0] mk;
      logic             ov;
      logic             clr;
      exp_t             e;
   } vec_t;

   exp_t sb[$];
   vec_t vecs[$];
   exp_t got;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   vec_no = 0;

   logic [PAT_W-1:0] tbl_pat  = 4'b1011;
   logic [PAT_W-1:0] tbl_mask = 4'b1111;

   task automatic add(input logic rst, input logic v, input logic b, input logic ld,
                      input logic ov, input logic clr,
                      input logic ey, input logic [CNT_W-1:0] ec, input logic [1:0] es);
      vec_t t;
      t.rst = rst; t.v = v; t.b = b; t.ld = ld; t.pat = tbl_pat; t.mk = tbl_mask;
      t.ov = ov; t.clr = clr; t.e = '{ey, ec, es};
      vecs.push_back(t);
   endtask

   // Monitor: compare outputs just after each rising edge against the scoreboard.
   always @(posedge clk) begin
      #1;
      if (sb.size() > 0) begin
         got = sb.pop_front();
         vec_no++;
         n_cmp++;
         if (y !== got.y) begin
            n_bad++;
            $display("FAIL y vec%0d: got %0b want %0b", vec_no, y, got.y);
         end
         n_cmp++;
         if (match_count !== got.cnt) begin
            n_bad++;
            $display("FAIL match_count vec%0d: got %0d want %0d", vec_no, match_count, got.cnt);
         end
         n_cmp++;
         if (state_o !== got.st) begin
            n_bad++;
            $display("FAIL state_o vec%0d: got %0d want %0d", vec_no, state_o, got.st);
         end
      end
   end

   initial begin
      reset_n = 1'b0; x = 1'b0; x_valid = 1'b0; cfg_load = 1'b0;
      cfg_pattern = '0; overlap = 1'b1; cnt_clr = 1'b0;
`ifdef SEQDET_MASK_EN
      cfg_mask = '1;
`endif

      // Reset, overlap=1, stream 1011011 with pattern 1011
      add(1,0,0,0, 1,0, 0,0,0);
      add(0,1,1,0, 1,0, 0,0,0);
      add(0,1,0,0, 1,0, 0,0,0);
      add(0,1,1,0, 1,0, 0,0,0);
      add(0,1,1,0, 1,0, 1,1,2);
      add(0,1,0,0, 1,0, 0,1,1);
      add(0,1,1,0, 1,0, 0,1,1);
      add(0,1,1,0, 1,0, 1,2,2);
      add(0,0,0,0, 1,0, 0,2,1);
      // Same stream, overlap=0 (load+clear first)
      add(0,1,1,1, 0,1, 0,0,0);
      add(0,1,1,0, 0,0, 0,0,0);
      add(0,1,0,0, 0,0, 0,0,0);
      add(0,1,1,0, 0,0, 0,0,0);
      add(0,1,1,0, 0,0, 1,1,2);
      add(0,1,0,0, 0,0, 0,1,0);
      add(0,1,1,0, 0,0, 0,1,0);
      add(0,1,1,0, 0,0, 0,1,0);
      add(0,1,0,0, 0,0, 0,1,1);
      // Pattern 1111, overlap=1: consecutive hits, saturation, clear vs hit
      tbl_pat = 4'b1111;
      add(0,0,0,1, 1,1, 0,0,0);
      add(0,1,1,0, 1,0, 0,0,0);
      add(0,1,1,0, 1,0, 0,0,0);
      add(0,1,1,0, 1,0, 0,0,0);
      add(0,1,1,0, 1,0, 1,1,2);
      add(0,1,1,0, 1,0, 1,2,2);
      add(0,1,1,0, 1,0, 1,3,2);
      add(0,0,0,0, 1,0, 0,3,1);
      add(0,1,1,0, 1,0, 1,3,2);
      add(0,1,1,0, 1,1, 1,0,2);
      add(0,0,0,0, 1,0, 0,0,1);
      // Non-overlap hit, then HIT exits to FILL on an idle cycle
      add(0,1,1,0, 0,0, 1,1,2);
      add(0,0,0,0, 0,0, 0,1,0);
      add(0,1,1,0, 0,0, 0,1,0);
      // Load 1011 with a discarded bit, then 1,0,<idle x3>,1,1
      tbl_pat = 4'b1011;
      add(0,1,1,1, 1,1, 0,0,0);
      add(0,1,1,0, 1,0, 0,0,0);
      add(0,1,0,0, 1,0, 0,0,0);
      add(0,0,0,0, 1,0, 0,0,0);
      add(0,0,0,0, 1,0, 0,0,0);
      add(0,0,0,0, 1,0, 0,0,0);
      add(0,1,1,0, 1,0, 0,0,0);
      add(0,1,1,0, 1,0, 1,1,2);
      add(0,0,0,0, 1,0, 0,1,1);
      // Reset mid-stream after 1,0,1; the next 1,0,1,1 must rebuild from scratch
      add(0,1,1,0, 1,0, 0,1,1);
      add(0,1,0,0, 1,0, 0,1,1);
      add(0,1,1,0, 1,0, 0,1,1);
      add(1,0,0,0, 1,0, 0,0,0);
      add(0,1,1,0, 1,0, 0,0,0);
      add(0,1,0,0, 1,0, 0,0,0);
      add(0,1,1,0, 1,0, 0,0,0);
      add(0,1,1,0, 1,0, 1,1,2);
`ifdef SEQDET_MASK_EN
      // Mask 1001 with pattern 1001: 1111 matches through the don't-care bits
      tbl_pat = 4'b1001; tbl_mask = 4'b1001;
      add(0,0,0,1, 1,0, 0,1,0);
      add(0,1,1,0, 1,0, 0,1,0);
      add(0,1,1,0, 1,0, 0,1,0);
      add(0,1,1,0, 1,0, 0,1,0);
      add(0,1,1,0, 1,0, 1,2,2);
`endif

      foreach (vecs[i]) begin
         @(negedge clk);
         reset_n     = !vecs[i].rst;
         x_valid     = vecs[i].v;
         x           = vecs[i].b;
         cfg_load    = vecs[i].ld;
         cfg_pattern = vecs[i].pat;
`ifdef SEQDET_MASK_EN
         cfg_mask    = vecs[i].mk;
`endif
         overlap     = vecs[i].ov;
         cnt_clr     = vecs[i].clr;
         sb.push_back(vecs[i].e);
      end
      @(negedge clk);
      x_valid = 1'b0; cfg_load = 1'b0; cnt_clr = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (sb.size() != 0) begin
         n_bad++;
         $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/seq_detector.md
Name: seq_detector

Overview:
- Parametrised serial bit-pattern detector; next generation of the team's small Moore pattern-recognition FSMs.
- Pattern length and counter width are parameters. Pattern is runtime-programmable.
- Supports overlapping and non-overlapping match modes and counts matches.
- Sits on a serial input path and raises a one-cycle registered match flag plus a saturating match count.

Parameters:
PAT_W, 4, pattern length in bits (≥2)
CNT_W, 8, match counter width
PAT_RESET, 4'b1011 (PAT_W bits), pattern register value after reset

Ports:
clk  input  1  clock, all state updates on rising edge
reset_n  input  1  asynchronous active-low reset
x  input  1  serial data bit
x_valid  input  1  x is sampled only when high
cfg_load  input  1  strobe: load cfg_pattern, clear history
cfg_pattern  input  PAT_W  new pattern; bit PAT_W-1 is the first-received bit
overlap  input  1  1 = overlapping matches allowed, 0 = non-overlapping
cnt_clr  input  1  synchronous clear of match_count
y  output  1  match pulse, registered (Moore: high iff state==HIT)
match_count  output  CNT_W  saturating number of matches
state_o  output  2  current state: FILL=0, HUNT=1, HIT=2

Behaviour:
- Reset (async, reset_n low):
  - hist=0, fill=0, pattern=PAT_RESET, state=FILL.
  - y=0, match_count=0.
- History:
  - On x_valid: hist <= {hist[PAT_W-2:0], x}.
  - fill <= min(fill+1, PAT_W).
- Match condition: x_valid, and the post-shift history equals pattern, and post-increment fill==PAT_W.
- State machine (evaluated each clk; "hit" = match condition):
  - FILL: hit -> HIT; else if new fill==PAT_W -> HUNT; else FILL.
  - HUNT: hit -> HIT; else HUNT.
  - HIT: hit -> HIT (back-to-back, overlap mode only); else if overlap=1 -> HUNT; else -> FILL.
- Non-overlap mode:
  - Entering HIT clears fill to 0 in the same edge.
  - The next match therefore needs PAT_W fresh valid bits.
  - HIT exits to FILL when the next valid bit arrives.
  - Also exits to FILL on the next cycle if x_valid is low.
- Latency: y rises on the clk edge that samples the completing bit and is observed the following cycle. It stays high one cycle per match.
- x_valid low: hist and fill hold. HIT still exits after one cycle: to HUNT if overlap=1, to FILL if overlap=0.
- match_count:
  - Increments on each entry or re-entry into HIT.
  - Saturates at 2^CNT_W-1.
  - cnt_clr has priority over increment in the same cycle: result is 0.
- cfg_load:
  - pattern <= cfg_pattern; hist <= 0; fill <= 0; state <= FILL.
  - Any x sampled in the same cycle is discarded.
  - match_count is unaffected.
- overlap may change at any time. It takes effect at the next state evaluation.
- No x/z propagation: unused state encoding 3 -> FILL.

Optional Feature:
- Macro SEQDET_MASK_EN.
- Defined:
  - Adds input cfg_mask[PAT_W-1:0], captured on cfg_load and reset to all-ones.
  - Compare is ((hist ^ pattern) & mask)==0; a mask bit of 0 is a don't-care.
  - fill requirement is unchanged.
- Undefined:
  - Port absent; exact compare of all PAT_W bits.

Test Plan:
- Reset with PAT_RESET=1011, overlap=1, stream 1,0,1,1,0,1,1 (x_valid=1 each cycle) -> y pulses after bit 4 and bit 7; match_count=2.
- Same stream, overlap=0 -> y pulses only after bit 4; match_count=1; state_o=FILL after bit 5.
- cfg_load pattern 1111, overlap=1, six consecutive 1s -> y high for 3 consecutive cycles (bits 4,5,6), stays HIT; match_count=3.
- CNT_W=2, 5 separated matches -> match_count saturates at 3. Then cnt_clr together with a hit -> match_count=0.
- x_valid gaps: bits 1,0,<idle 3 cycles>,1,1 with pattern 1011 -> single y pulse after final bit; history held across idle cycles.
- reset_n asserted mid-stream after 3 matching bits, released, next bit 1 -> no match; state FILL, fill=1, y=0. With SEQDET_MASK_EN, mask 1001 and pattern 1001: stream 1,1,1,1 -> match.
